sync_fifo_gen: RTL and testbench

- Parametrised single-clock FIFO; successor to the fixed 8-bit, 16-deep vendor FIFO cores.
- Generalised in data width, depth, read mode (standard or FWFT) and programmable thresholds.
- Same status set as the cores (wr_ack, overflow, valid, underflow, almost flags, data count), plus programmable full/empty flags.
- Sits between producer and consumer logic inside one clock domain.

---
 rtl/sync_fifo_gen_pkg.sv | 16 +
 rtl/sync_fifo_gen_if.sv | 39 +++
 rtl/sync_fifo_gen_ram.sv | 35 +++
 rtl/sync_fifo_gen.sv | 136 +++++++++++++
 tb/tb_sync_fifo_gen.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_gen_pkg.sv
// Shared constants and sizing helpers for the sync_fifo_gen FIFO family.
package sync_fifo_gen_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int fifo_cnt_w(input int depth_log2);
        return depth_log2 + 1;
    endfunction

    // FWFT holds one extra word in the output register beyond the RAM.
    function automatic int fifo_cap(input int depth_log2, input int fwft);
        return (1 << depth_log2) + ((fwft == FIFO_MODE_FWFT) ? 1 : 0);
    endfunction

endpackage

// File: rtl/sync_fifo_gen_if.sv
// Handshake, data and status bundle of sync_fifo_gen; the FIFO is the slave side.
interface sync_fifo_gen_if #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4
);
    import sync_fifo_gen_pkg::*;

    localparam int CNT_W = fifo_cnt_w(DEPTH_LOG2);

    logic [DATA_W-1:0] din;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] dout;
    logic              full;
    logic              almost_full;
    logic              prog_full;
    logic              empty;
    logic              almost_empty;
    logic              prog_empty;
    logic              wr_ack;
    logic              overflow;
    logic              valid;
    logic              underflow;
    logic [CNT_W-1:0]  data_count;
    logic              parity_err;

    modport master (
        output din, wr_en, rd_en,
        input  dout, full, almost_full, prog_full, empty, almost_empty, prog_empty,
        input  wr_ack, overflow, valid, underflow, data_count, parity_err
    );

    modport slave (
        input  din, wr_en, rd_en,
        output dout, full, almost_full, prog_full, empty, almost_empty, prog_empty,
        output wr_ack, overflow, valid, underflow, data_count, parity_err
    );

endinterface

// File: rtl/sync_fifo_gen_ram.sv
// Simple dual-port RAM: synchronous write, registered read with resettable output.
import sync_fifo_gen_pkg::*;

module sync_fifo_gen_ram #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The read register doubles as the FIFO dout, so it must clear on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_gen.sv
// Parametrised single-clock FIFO, standard or FWFT read, with registered status flags.
// Optional even-parity protection of stored words: define SYNC_FIFO_GEN_PARITY_EN.
import sync_fifo_gen_pkg::*;

module sync_fifo_gen #(
    parameter int DATA_W            = 8,
    parameter int DEPTH_LOG2        = 4,
    parameter int FWFT              = 0,
    parameter int PROG_FULL_THRESH  = 12,
    parameter int PROG_EMPTY_THRESH = 2
) (
    input  logic           clk,
    input  logic           rst,
    sync_fifo_gen_if.slave bus
);

    localparam int CNT_W   = fifo_cnt_w(DEPTH_LOG2);
    localparam int CAP     = fifo_cap(DEPTH_LOG2, FWFT);
    localparam bit IS_FWFT = (FWFT == FIFO_MODE_FWFT);

    localparam logic [CNT_W-1:0] CAP_C  = CNT_W'(CAP);
    localparam logic [CNT_W-1:0] AF_C   = CNT_W'(CAP - 1);
    localparam logic [CNT_W-1:0] PF_C   = CNT_W'(PROG_FULL_THRESH);
    localparam logic [CNT_W-1:0] PE_C   = CNT_W'(PROG_EMPTY_THRESH);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C = '0;

`ifdef SYNC_FIFO_GEN_PARITY_EN
    localparam int RAM_W = DATA_W + 1;
`else
    localparam int RAM_W = DATA_W;
`endif

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      ram_count;
    logic [CNT_W-1:0]      count_next;
    logic [CNT_W-1:0]      ram_count_next;
    logic                  present;
    logic                  present_next;
    logic                  rd_fire_q;
    logic                  can_write;
    logic                  pop;
    logic                  ram_rd;
    logic                  underflow_next;
    logic [RAM_W-1:0]      ram_wdata;
    logic [RAM_W-1:0]      ram_q;

    // pop removes a word from the FIFO; ram_rd moves a word out of the RAM.
    // They coincide in standard mode; in FWFT ram_rd is the prefetch.
    always_comb begin
        can_write = bus.wr_en & ~bus.full;
        if (IS_FWFT) begin
            pop            = bus.rd_en & present;
            ram_rd         = (ram_count != ZERO_C) & (~present | pop);
            underflow_next = bus.rd_en & ~present;
            present_next   = ram_rd | (present & ~pop);
        end else begin
            pop            = bus.rd_en & ~bus.empty;
            ram_rd         = pop;
            underflow_next = bus.rd_en & bus.empty;
            present_next   = 1'b0;
        end
        count_next     = count + CNT_W'(can_write) - CNT_W'(pop);
        ram_count_next = ram_count + CNT_W'(can_write) - CNT_W'(ram_rd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            ram_count        <= '0;
            present          <= 1'b0;
            rd_fire_q        <= 1'b0;
            bus.wr_ack       <= 1'b0;
            bus.overflow     <= 1'b0;
            bus.underflow    <= 1'b0;
            bus.full         <= 1'b0;
            bus.almost_full  <= 1'b0;
            bus.prog_full    <= 1'b0;
            bus.empty        <= 1'b1;
            bus.almost_empty <= 1'b1;
            bus.prog_empty   <= 1'b1;
        end else begin
            if (can_write) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (ram_rd) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            count            <= count_next;
            ram_count        <= ram_count_next;
            present          <= present_next;
            rd_fire_q        <= ram_rd;
            bus.wr_ack       <= can_write;
            bus.overflow     <= bus.wr_en & bus.full;
            bus.underflow    <= underflow_next;
            bus.full         <= (count_next == CAP_C);
            bus.almost_full  <= (count_next >= AF_C);
            bus.prog_full    <= (count_next >= PF_C);
            bus.empty        <= IS_FWFT ? ~present_next : (count_next == ZERO_C);
            bus.almost_empty <= (count_next <= ONE_C);
            bus.prog_empty   <= (count_next <= PE_C);
        end
    end

    assign bus.data_count = count;
    assign bus.valid      = IS_FWFT ? present : rd_fire_q;
    assign bus.dout       = ram_q[DATA_W-1:0];

`ifdef SYNC_FIFO_GEN_PARITY_EN
    // rd_fire_q marks the first cycle a freshly read word sits on dout.
    assign ram_wdata      = {^bus.din, bus.din};
    assign bus.parity_err = rd_fire_q & (^ram_q);
`else
    assign ram_wdata      = bus.din;
    assign bus.parity_err = 1'b0;
`endif

    sync_fifo_gen_ram #(
        .WIDTH  (RAM_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (can_write),
        .waddr (wr_ptr),
        .wdata (ram_wdata),
        .re    (ram_rd),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_sync_fifo_gen.sv
// Self-checking bench: a standard and an FWFT instance checked every cycle against queue models.
module tb_sync_fifo_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s_corrupt = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    sync_fifo_gen_if #(.DATA_W(8), .DEPTH_LOG2(4)) s_bus ();
    sync_fifo_gen_if #(.DATA_W(8), .DEPTH_LOG2(4)) f_bus ();

    sync_fifo_gen #(.DATA_W(8), .DEPTH_LOG2(4), .FWFT(0),
                    .PROG_FULL_THRESH(12), .PROG_EMPTY_THRESH(2)) dut_std (
        .clk (clk),
        .rst (rst),
        .bus (s_bus)
    );

    sync_fifo_gen #(.DATA_W(8), .DEPTH_LOG2(4), .FWFT(1),
                    .PROG_FULL_THRESH(12), .PROG_EMPTY_THRESH(2)) dut_fwft (
        .clk (clk),
        .rst (rst),
        .bus (f_bus)
    );

    // Model state: queues of words (bit 8 marks a word with a planted bit flip).
    logic [8:0] sq[$];
    logic [8:0] fq[$];
    logic [7:0] s_dout, f_dout;
    logic       s_ack, s_ovf, s_vld, s_unf, s_perr;
    logic       f_ack, f_ovf, f_shown, f_unf;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [23:0] packExp(logic [7:0] d, int n, int cap, logic emp,
                                            logic ack, logic ovf, logic vld, logic unf, logic perr);
        return {d, 5'(n), n == cap, n >= cap - 1, n >= 12, emp, n <= 1, n <= 2,
                ack, ovf, vld, unf, perr};
    endfunction

    task automatic modelUpdate();
        logic [8:0] w;
        if (rst) begin
            sq.delete();
            fq.delete();
            s_dout = 8'h00; f_dout = 8'h00;
            {s_ack, s_ovf, s_vld, s_unf, s_perr} = '0;
            {f_ack, f_ovf, f_shown, f_unf} = '0;
        end else begin
            if (s_corrupt && sq.size() > 0) sq[0] = sq[0] ^ 9'h108;
            s_ack  = s_bus.wr_en && sq.size() < 16;
            s_ovf  = s_bus.wr_en && sq.size() == 16;
            s_vld  = s_bus.rd_en && sq.size() > 0;
            s_unf  = s_bus.rd_en && sq.size() == 0;
            s_perr = 1'b0;
            if (s_vld) begin
                w = sq.pop_front();
                s_dout = w[7:0];
                s_perr = w[8];
            end
            if (s_ack) sq.push_back({1'b0, s_bus.din});

            f_ack = f_bus.wr_en && fq.size() < 17;
            f_ovf = f_bus.wr_en && fq.size() == 17;
            f_unf = f_bus.rd_en && !f_shown;
            if (f_bus.rd_en && f_shown) w = fq.pop_front();
            f_shown = fq.size() > 0;
            if (f_shown) f_dout = fq[0][7:0];
            if (f_ack) fq.push_back({1'b0, f_bus.din});
        end
    endtask

    task automatic compareAll();
        checkOutput("std outputs",
            {8'h0, s_bus.dout, s_bus.data_count, s_bus.full, s_bus.almost_full, s_bus.prog_full,
             s_bus.empty, s_bus.almost_empty, s_bus.prog_empty, s_bus.wr_ack, s_bus.overflow,
             s_bus.valid, s_bus.underflow, s_bus.parity_err},
            {8'h0, packExp(s_dout, sq.size(), 16, sq.size() == 0, s_ack, s_ovf, s_vld, s_unf, s_perr)});
        checkOutput("fwft outputs",
            {8'h0, f_bus.dout, f_bus.data_count, f_bus.full, f_bus.almost_full, f_bus.prog_full,
             f_bus.empty, f_bus.almost_empty, f_bus.prog_empty, f_bus.wr_ack, f_bus.overflow,
             f_bus.valid, f_bus.underflow, f_bus.parity_err},
            {8'h0, packExp(f_dout, fq.size(), 17, !f_shown, f_ack, f_ovf, f_shown, f_unf, 1'b0)});
    endtask

    // One clock: drive at the negedge, update the model at posedge, compare at the next negedge.
    task automatic applyStimulus(input logic sw, input logic sr, input logic [7:0] sd,
                                 input logic fw, input logic fr, input logic [7:0] fd);
        s_bus.wr_en = sw; s_bus.rd_en = sr; s_bus.din = sd;
        f_bus.wr_en = fw; f_bus.rd_en = fr; f_bus.din = fd;
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
        cyc++;
        compareAll();
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(0, 0, 8'h00, 0, 0, 8'h00);
    endtask

    task automatic stdWr(input logic [7:0] d); applyStimulus(1, 0, d, 0, 0, 8'h00); endtask
    task automatic stdRd();                    applyStimulus(0, 1, 8'h00, 0, 0, 8'h00); endtask
    task automatic fwWr(input logic [7:0] d);  applyStimulus(0, 0, 8'h00, 1, 0, d); endtask
    task automatic fwRd();                     applyStimulus(0, 0, 8'h00, 0, 1, 8'h00); endtask

    task automatic resetCycle();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
    endtask

    logic [7:0] t1_words [3];

    initial begin
        t1_words = '{8'hFF, 8'hFE, 8'hFD};
        resetCycle();
        checkOutput("reset std empty", s_bus.empty, 1);
        checkOutput("reset std count", s_bus.data_count, 0);
        checkOutput("reset std dout", s_bus.dout, 8'h00);
        checkOutput("reset fwft empty", f_bus.empty, 1);

        // Standard mode: three spaced writes, four spaced reads
        stdWr(8'hFF); idle(9);
        stdWr(8'hFE); idle(9);
        stdWr(8'hFD); idle(9);
        checkOutput("t1 count 3", s_bus.data_count, 3);
        for (int i = 0; i < 4; i++) begin
            stdRd();
            if (i < 3) begin
                checkOutput("t1 read dout", s_bus.dout, t1_words[i]);
                checkOutput("t1 read valid", s_bus.valid, 1);
            end else begin
                checkOutput("t1 4th underflow", s_bus.underflow, 1);
                checkOutput("t1 4th valid", s_bus.valid, 0);
            end
            idle(9);
        end
        checkOutput("t1 end count", s_bus.data_count, 0);
        checkOutput("t1 end empty", s_bus.empty, 1);

        // FWFT: single word falls through and holds until acknowledged
        fwWr(8'hFF);
        checkOutput("t2 not yet valid", f_bus.valid, 0);
        idle(1);
        checkOutput("t2 dout", f_bus.dout, 8'hFF);
        checkOutput("t2 valid", f_bus.valid, 1);
        checkOutput("t2 empty", f_bus.empty, 0);
        idle(5);
        checkOutput("t2 held dout", f_bus.dout, 8'hFF);
        fwRd();
        checkOutput("t2 popped valid", f_bus.valid, 0);
        checkOutput("t2 popped empty", f_bus.empty, 1);

        // Standard fill to full and overflow
        resetCycle();
        for (int i = 0; i < 16; i++) begin
            stdWr(8'(i));
            if (i == 10) checkOutput("t3 prog_full at 11", s_bus.prog_full, 0);
            if (i == 11) checkOutput("t3 prog_full at 12", s_bus.prog_full, 1);
            if (i == 14) checkOutput("t3 almost_full at 15", {s_bus.almost_full, s_bus.full}, 2'b10);
            if (i == 15) checkOutput("t3 full at 16", s_bus.full, 1);
        end
        stdWr(8'hAA);
        checkOutput("t3 overflow", {s_bus.overflow, s_bus.wr_ack}, 2'b10);
        checkOutput("t3 count 16", s_bus.data_count, 16);

        // Simultaneous read/write while full
        applyStimulus(1, 1, 8'hBB, 0, 0, 8'h00);
        checkOutput("t4 full rw dout", s_bus.dout, 8'h00);
        checkOutput("t4 full rw flags", {s_bus.valid, s_bus.overflow}, 2'b11);
        checkOutput("t4 full rw count", s_bus.data_count, 15);
        for (int i = 1; i < 16; i++) begin
            stdRd();
            checkOutput("t3 drain word", s_bus.dout, 8'(i));
        end
        stdRd();
        checkOutput("t3 no extra word", s_bus.underflow, 1);

        // Simultaneous read/write while empty
        applyStimulus(1, 1, 8'h77, 0, 0, 8'h00);
        checkOutput("t4 empty rw underflow", s_bus.underflow, 1);
        checkOutput("t4 empty rw count", s_bus.data_count, 1);
        stdRd();
        checkOutput("t4 empty rw data", s_bus.dout, 8'h77);

        // FWFT fill to 17, overflow, back-to-back drain, mixed traffic
        for (int i = 0; i < 17; i++) fwWr(8'(8'h20 + i));
        checkOutput("fwft full count", f_bus.data_count, 17);
        checkOutput("fwft full flag", f_bus.full, 1);
        fwWr(8'hEE);
        checkOutput("fwft overflow", f_bus.overflow, 1);
        checkOutput("fwft head", f_bus.dout, 8'h20);
        for (int i = 0; i < 17; i++) fwRd();
        checkOutput("fwft drained", f_bus.empty, 1);
        applyStimulus(0, 0, 8'h00, 1, 1, 8'h61);
        applyStimulus(0, 0, 8'h00, 1, 1, 8'h62);
        applyStimulus(0, 0, 8'h00, 1, 1, 8'h63);
        idle(2);
        fwRd(); fwRd(); fwRd();

        // Reset mid-operation with 8 words held
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 8'(8'h40 + i), 1, 0, 8'(8'h50 + i));
        checkOutput("t5 count 8", s_bus.data_count, 8);
        resetCycle();
        checkOutput("t5 count", s_bus.data_count, 0);
        checkOutput("t5 empty flags", {s_bus.empty, s_bus.almost_empty, s_bus.prog_empty, s_bus.full}, 4'b1110);
        checkOutput("t5 dout", s_bus.dout, 8'h00);
        checkOutput("t5 fwft count", f_bus.data_count, 0);
        stdWr(8'h33);
        stdRd();
        checkOutput("t5 new data", s_bus.dout, 8'h33);
        fwWr(8'h44);
        idle(1);
        checkOutput("t5 fwft new data", f_bus.dout, 8'h44);
        fwRd();

`ifdef SYNC_FIFO_GEN_PARITY_EN
        // Parity: flip bit 3 of the word stored at address 0
        resetCycle();
        stdWr(8'h5A);
        s_corrupt = 1'b1;
        dut_std.u_ram.mem[0] <= dut_std.u_ram.mem[0] ^ 9'h008;
        idle(1);
        s_corrupt = 1'b0;
        stdRd();
        checkOutput("t6 corrupt dout", s_bus.dout, 8'h52);
        checkOutput("t6 parity_err", {s_bus.valid, s_bus.parity_err}, 2'b11);
        stdWr(8'hA5);
        stdRd();
        checkOutput("t6 clean parity", {s_bus.valid, s_bus.parity_err}, 2'b10);
`endif

        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
